// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - boot-time Avalon-MM reader that checks the system-ID and timestamp words
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1457992953,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1,
    parameter bit          USE_RDV        = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WT_ID,
        S_RD_TS,
        S_WT_TS,
        S_DONE
    } state_t;

    // The transaction expires on the cycle the counter holds TIMEOUT_CYCLES-1, so
    // read stays asserted for exactly TIMEOUT_CYCLES cycles when the slave never answers.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        auto_pending;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        launch;
    logic        cap_id;
    logic        cap_ts;
    logic        expire;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // State register; auto_pending remembers that a post-reset launch is still owed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            auto_pending <= AUTO_START;
        end else begin
            state <= state_next;
            if (launch) begin
                auto_pending <= 1'b0;
            end
        end
    end

    // Next-state and bus outputs; bus signals decode straight from state so reset drops them at once.
    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b0;
        launch      = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        expire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (auto_pending || start) begin
                    launch     = 1'b1;
                    state_next = S_RD_ID;
                end
            end
            S_RD_ID: begin
                avm_read = 1'b1;
                busy     = 1'b1;
                if (!avm_waitrequest) begin
                    if (USE_RDV) begin
                        state_next = S_WT_ID;
                    end else begin
                        cap_id     = 1'b1;
                        state_next = S_RD_TS;
                    end
                end else if (tmo_hit) begin
                    expire     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_WT_ID: begin
                busy = 1'b1;
                if (avm_readdatavalid) begin
                    cap_id     = 1'b1;
                    state_next = S_RD_TS;
                end else if (tmo_hit) begin
                    expire     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                busy        = 1'b1;
                if (!avm_waitrequest) begin
                    if (USE_RDV) begin
                        state_next = S_WT_TS;
                    end else begin
                        cap_ts     = 1'b1;
                        state_next = S_DONE;
                    end
                end else if (tmo_hit) begin
                    expire     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_WT_TS: begin
                busy = 1'b1;
                if (avm_readdatavalid) begin
                    cap_ts     = 1'b1;
                    state_next = S_DONE;
                end else if (tmo_hit) begin
                    expire     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = S_RD_ID;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture, compare and timeout bookkeeping; the timestamp is compared straight off the bus
    // so all result flags land together with DONE entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= 32'd0;
            ts_value <= 32'd0;
            tmo_cnt  <= 16'd0;
        end else if (launch) begin
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= 32'd0;
            ts_value <= 32'd0;
            tmo_cnt  <= 16'd0;
        end else if (cap_id) begin
            id_value <= avm_readdata;
            tmo_cnt  <= 16'd0;
        end else if (cap_ts) begin
            ts_value <= avm_readdata;
            done     <= 1'b1;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (avm_readdata == EXPECTED_TS);
        end else if (expire) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb/tb_sysid_boot_checker.sv - self-checking bench for sysid_boot_checker
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_TS = 32'd1457992953;
    localparam logic [31:0] TS_BAD = 32'd1457992952;

    typedef struct {
        int          wait_id;
        int          wait_ts;
        logic [31:0] id_data;
        logic [31:0] ts_data;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] id_val;
        logic [31:0] ts_val;
        int          lat;
        logic        addr1;
    } vec_t;

    typedef struct {
        int          dut;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] id_val;
        logic [31:0] ts_val;
        int          done_cyc;
        logic        addr1;
    } exp_t;

    logic        clock = 1'b0;
    logic [1:0]  rst;
    logic        start_a, start_b;
    logic        wr_a, rdv_b;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  avm_address, avm_read, busy, done, id_ok, ts_ok, tmo;
    logic [31:0] idv_a, idv_b, tsv_a, tsv_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stray_cyc = -1;
    logic        saw_addr1;
    exp_t        sb_q[$];
    vec_t        vecs[9];

    int          cfg_wait_id, cfg_wait_ts;
    logic [31:0] cfg_id_a, cfg_ts_a, cfg_id_b, cfg_ts_b;

    always #5 clock = ~clock;

    sysid_boot_checker #(
        .TIMEOUT_CYCLES(8), .AUTO_START(1'b1), .USE_RDV(1'b0)
    ) dut_a (
        .clock(clock), .reset(rst[0]), .start(start_a),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]),
        .avm_waitrequest(wr_a), .avm_readdata(rdata_a), .avm_readdatavalid(1'b0),
        .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
        .timeout(tmo[0]), .id_value(idv_a), .ts_value(tsv_a)
    );

    sysid_boot_checker #(
        .AUTO_START(1'b0), .USE_RDV(1'b1)
    ) dut_b (
        .clock(clock), .reset(rst[1]), .start(start_b),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]),
        .avm_waitrequest(1'b0), .avm_readdata(rdata_b), .avm_readdatavalid(rdv_b),
        .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
        .timeout(tmo[1]), .id_value(idv_b), .ts_value(tsv_b)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic done_seen(input int d);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected done: dut %0d rose done with nothing expected", d);
        end else begin
            e = sb_q.pop_front();
            check_word("done dut", 32'(d), 32'(e.dut));
            check_word("done cycle", 32'(cyc), 32'(e.done_cyc));
            check_bit("id_ok", id_ok[d], e.id_ok);
            check_bit("ts_ok", ts_ok[d], e.ts_ok);
            check_bit("timeout", tmo[d], e.tmo);
            check_bit("busy at done", busy[d], 1'b0);
            check_word("id_value", (d == 0) ? idv_a : idv_b, e.id_val);
            check_word("ts_value", (d == 0) ? tsv_a : tsv_b, e.ts_val);
            if (d == 0) begin
                check_bit("address 1 issued", saw_addr1, e.addr1);
                saw_addr1 = 1'b0;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (sb_q.size() == 0) return;
            @(negedge clock);
        end
        checks++;
        errors++;
        $display("FAIL drain timeout: %0d result(s) never produced", sb_q.size());
        sb_q.delete();
    endtask

    task automatic run_vec(input int i, input bit first);
        exp_t e;
        @(negedge clock);
        cfg_wait_id = vecs[i].wait_id;
        cfg_wait_ts = vecs[i].wait_ts;
        cfg_id_a    = vecs[i].id_data;
        cfg_ts_a    = vecs[i].ts_data;
        if (first) begin
            stray_cyc = cyc + 2;
            rst = 2'b00;
        end else begin
            start_a = 1'b1;
        end
        e = '{0, vecs[i].id_ok, vecs[i].ts_ok, vecs[i].tmo, vecs[i].id_val, vecs[i].ts_val,
              cyc + vecs[i].lat, vecs[i].addr1};
        sb_q.push_back(e);
        @(negedge clock);
        start_a = 1'b0;
        wait_drain();
    endtask

    initial forever @(posedge clock) cyc++;

    // Slave A: programmable waitrequest stall per address, also checks request stability while stalled.
    initial begin
        logic act, cur_addr, prev_wait, prev_addr;
        int   cur_wait;
        act = 1'b0; cur_addr = 1'b0; prev_wait = 1'b0; prev_addr = 1'b0; cur_wait = 0;
        wr_a = 1'b0; rdata_a = 32'd0;
        forever begin
            @(negedge clock);
            if (rst[0]) begin
                act = 1'b0; prev_wait = 1'b0; wr_a = 1'b0;
            end else begin
                if (prev_wait && !tmo[0]) begin
                    check_bit("read held in stall", avm_read[0], 1'b1);
                    check_bit("address held in stall", avm_address[0], prev_addr);
                end
                if (avm_read[0]) begin
                    if (!act || avm_address[0] != cur_addr) begin
                        act      = 1'b1;
                        cur_addr = avm_address[0];
                        cur_wait = cur_addr ? cfg_wait_ts : cfg_wait_id;
                    end
                    if (cur_wait > 0) begin
                        wr_a = 1'b1;
                        cur_wait--;
                    end else begin
                        wr_a = 1'b0;
                    end
                    rdata_a = cur_addr ? cfg_ts_a : cfg_id_a;
                end else begin
                    act  = 1'b0;
                    wr_a = 1'b0;
                end
                prev_wait = avm_read[0] && wr_a;
                prev_addr = avm_address[0];
            end
        end
    end

    // Slave B: never stalls, returns data 3 cycles after accept, plus one scheduled stray valid.
    initial begin
        int          pend;
        logic [31:0] pend_data;
        pend = 0; pend_data = 32'd0; rdv_b = 1'b0; rdata_b = 32'd0;
        forever begin
            @(negedge clock);
            rdv_b = 1'b0;
            if (rst[1]) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        rdv_b   = 1'b1;
                        rdata_b = pend_data;
                    end
                end
                if (cyc == stray_cyc) begin
                    rdv_b   = 1'b1;
                    rdata_b = 32'hBAD0_0BAD;
                end
                if (avm_read[1]) begin
                    pend      = 3;
                    pend_data = avm_address[1] ? cfg_ts_b : cfg_id_b;
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on every rising done.
    initial begin
        logic prev_a, prev_b;
        prev_a = 1'b0; prev_b = 1'b0; saw_addr1 = 1'b0;
        forever begin
            @(negedge clock);
            if (avm_read[0] && avm_address[0]) saw_addr1 = 1'b1;
            if (done[0] && !prev_a) done_seen(0);
            if (done[1] && !prev_b) done_seen(1);
            prev_a = done[0];
            prev_b = done[1];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vecs[0] = '{0,   0,   32'd0,          EXP_TS, 1'b1, 1'b1, 1'b0, 32'd0,          EXP_TS, 3,  1'b1};
        vecs[1] = '{0,   0,   32'd0,          TS_BAD, 1'b1, 1'b0, 1'b0, 32'd0,          TS_BAD, 3,  1'b1};
        vecs[2] = '{4,   0,   32'd0,          EXP_TS, 1'b1, 1'b1, 1'b0, 32'd0,          EXP_TS, 7,  1'b1};
        vecs[3] = '{999, 0,   32'd0,          EXP_TS, 1'b0, 1'b0, 1'b1, 32'd0,          32'd0,  9,  1'b0};
        vecs[4] = '{0,   2,   32'hDEAD_BEEF,  EXP_TS, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF,  EXP_TS, 5,  1'b1};
        vecs[5] = '{0,   7,   32'd0,          EXP_TS, 1'b1, 1'b1, 1'b0, 32'd0,          EXP_TS, 10, 1'b1};
        vecs[6] = '{0,   999, 32'h0000_1234,  EXP_TS, 1'b0, 1'b0, 1'b1, 32'h0000_1234,  32'd0,  10, 1'b1};
        vecs[7] = '{8,   0,   32'd0,          EXP_TS, 1'b0, 1'b0, 1'b1, 32'd0,          32'd0,  9,  1'b0};
        vecs[8] = '{0,   0,   32'd0,          EXP_TS, 1'b1, 1'b1, 1'b0, 32'd0,          EXP_TS, 3,  1'b1};

        rst = 2'b11; start_a = 1'b0; start_b = 1'b0;
        cfg_wait_id = 0; cfg_wait_ts = 0; cfg_id_a = 32'd0; cfg_ts_a = EXP_TS;
        cfg_id_b = 32'd0; cfg_ts_b = EXP_TS;

        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check_bit("reset avm_read", avm_read[d], 1'b0);
            check_bit("reset avm_address", avm_address[d], 1'b0);
            check_bit("reset busy", busy[d], 1'b0);
            check_bit("reset done", done[d], 1'b0);
            check_bit("reset id_ok", id_ok[d], 1'b0);
            check_bit("reset ts_ok", ts_ok[d], 1'b0);
            check_bit("reset timeout", tmo[d], 1'b0);
        end
        check_word("reset id_value a", idv_a, 32'd0);
        check_word("reset ts_value a", tsv_a, 32'd0);
        check_word("reset id_value b", idv_b, 32'd0);

        for (int i = 0; i < 9; i++) run_vec(i, i == 0);

        // B stayed idle through all of that, including a stray readdatavalid.
        check_bit("b idle busy", busy[1], 1'b0);
        check_bit("b idle read", avm_read[1], 1'b0);
        check_word("b stray ignored", idv_b, 32'd0);

        // A: reset during the timestamp read, then automatic relaunch.
        @(negedge clock);
        cfg_wait_id = 0; cfg_wait_ts = 0; cfg_id_a = 32'h0000_0055; cfg_ts_a = EXP_TS;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        check_bit("a ts read issued", avm_read[0], 1'b1);
        check_bit("a ts address", avm_address[0], 1'b1);
        check_word("a id captured", idv_a, 32'h0000_0055);
        #2 rst[0] = 1'b1;
        #1;
        check_bit("a async read drop", avm_read[0], 1'b0);
        check_bit("a async busy drop", busy[0], 1'b0);
        check_word("a async id clear", idv_a, 32'd0);
        cfg_id_a = 32'd0;
        repeat (2) @(negedge clock);
        rst[0] = 1'b0;
        e = '{0, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, cyc + 3, 1'b1};
        sb_q.push_back(e);
        wait_drain();

        // B: manual start with a second start while busy, which must not disturb timing.
        @(negedge clock);
        start_b = 1'b1;
        e = '{1, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, cyc + 9, 1'b0};
        sb_q.push_back(e);
        @(negedge clock);
        start_b = 1'b0;
        repeat (2) @(negedge clock);
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        wait_drain();

        // Stray readdatavalid in DONE leaves the captured words alone.
        stray_cyc = cyc + 2;
        repeat (4) @(negedge clock);
        check_bit("b done held", done[1], 1'b1);
        check_word("b stray done id", idv_b, 32'd0);
        check_word("b stray done ts", tsv_b, EXP_TS);

        // Restart from DONE clears results immediately, re-runs with a bad timestamp.
        cfg_ts_b = TS_BAD;
        start_b = 1'b1;
        e = '{1, 1'b1, 1'b0, 1'b0, 32'd0, TS_BAD, cyc + 9, 1'b0};
        sb_q.push_back(e);
        @(negedge clock);
        start_b = 1'b0;
        check_bit("b relaunch busy", busy[1], 1'b1);
        check_bit("b relaunch done clr", done[1], 1'b0);
        check_bit("b relaunch id_ok clr", id_ok[1], 1'b0);
        check_bit("b relaunch ts_ok clr", ts_ok[1], 1'b0);
        check_word("b relaunch ts clr", tsv_b, 32'd0);
        wait_drain();

        // B: reset mid-read; without auto start it must stay idle afterwards.
        @(negedge clock);
        cfg_id_b = 32'h0000_0077; cfg_ts_b = EXP_TS;
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        repeat (4) @(negedge clock);
        check_bit("b ts read issued", avm_read[1], 1'b1);
        check_bit("b ts address", avm_address[1], 1'b1);
        check_word("b id captured", idv_b, 32'h0000_0077);
        #2 rst[1] = 1'b1;
        #1;
        check_bit("b async read drop", avm_read[1], 1'b0);
        check_bit("b async address drop", avm_address[1], 1'b0);
        check_bit("b async busy drop", busy[1], 1'b0);
        check_word("b async id clear", idv_b, 32'd0);
        repeat (2) @(negedge clock);
        rst[1] = 1'b0;
        repeat (4) @(negedge clock);
        check_bit("b no auto start", busy[1], 1'b0);
        check_bit("b no auto read", avm_read[1], 1'b0);
        check_bit("b no done", done[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
